// File: rtl/zigbee_mode_ctrl.sv
// zigbee_mode_ctrl: drains, soft-resets and settles the datapath around every sel change.
// Define ZIGBEE_MODE_LOCK_EN to add mode_lock_i, which holds off new requests in RUN.
module zigbee_mode_ctrl #(
    parameter logic [1:0] RESET_MODE    = 2'b00,
    parameter int         RESET_CYCLES  = 2,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         DRAIN_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] mode_req_i,
    input  logic       mode_req_valid_i,
    output logic       mode_req_ready_o,
    input  logic       chain_busy_i,
`ifdef ZIGBEE_MODE_LOCK_EN
    input  logic       mode_lock_i,
`endif
    output logic [1:0] sel_o,
    output logic       chain_resetn_o,
    output logic       chain_en_o,
    output logic       switching_o,
    output logic       timeout_o
);

    localparam int MAX_PHASE = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int PW        = $clog2(MAX_PHASE + 1);
    localparam int DW        = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [PW-1:0] RESET_LAST  = PW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_RESET,
        ST_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [1:0]    target_q, target_d;
    logic [1:0]    sel_q, sel_d;
    logic          resetn_q, resetn_d;
    logic          en_q, en_d;
    logic          ready_q, ready_d;
    logic          switching_q, switching_d;
    logic          timeout_q, timeout_d;

    logic accept;
    logic accept_switch;
    logic drain_timeout;
    logic run_ready;

    // ready_q is only ever high in RUN, so it fully qualifies the handshake
    assign accept        = mode_req_valid_i & ready_q;
    assign accept_switch = accept && (mode_req_i != sel_q);
    assign drain_timeout = (state_q == ST_DRAIN) && chain_busy_i
                           && (drain_cnt_q == DRAIN_LAST);

`ifdef ZIGBEE_MODE_LOCK_EN
    assign run_ready = ~mode_lock_i;
`else
    assign run_ready = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_RESET;
            phase_cnt_q <= '0;
            drain_cnt_q <= '0;
            target_q    <= RESET_MODE;
            sel_q       <= RESET_MODE;
            resetn_q    <= 1'b0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            switching_q <= 1'b1;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            target_q    <= target_d;
            sel_q       <= sel_d;
            resetn_q    <= resetn_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            switching_q <= switching_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept_switch) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!chain_busy_i || drain_timeout) begin
                    state_d = ST_RESET;
                end
            end
            ST_RESET: begin
                if (phase_cnt_q == RESET_LAST) begin
                    state_d = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (phase_cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        phase_cnt_d = '0;
        if ((state_d == state_q)
            && ((state_q == ST_RESET) || (state_q == ST_SETTLE))) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
        end

        drain_cnt_d = '0;
        if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
            drain_cnt_d = (drain_cnt_q == '1) ? drain_cnt_q : drain_cnt_q + 1'b1;
        end

        target_d = accept_switch ? mode_req_i : target_q;

        // sel only moves on the edge that also pulls the soft reset low
        sel_d = sel_q;
        if ((state_q == ST_DRAIN) && (state_d == ST_RESET)) begin
            sel_d = target_q;
        end

        resetn_d    = (state_d != ST_RESET);
        en_d        = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN) && run_ready;
        switching_d = (state_d != ST_RUN);

        timeout_d = timeout_q;
        if (accept) begin
            timeout_d = 1'b0;
        end else if (drain_timeout) begin
            timeout_d = 1'b1;
        end
    end

    assign sel_o            = sel_q;
    assign chain_resetn_o   = resetn_q;
    assign chain_en_o       = en_q;
    assign mode_req_ready_o = ready_q;
    assign switching_o      = switching_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_zigbee_mode_ctrl.sv
// tb_zigbee_mode_ctrl: randomized mode switches checked against a timing model
// derived from drain length, soft-reset length and settle length.
module tb_zigbee_mode_ctrl;

    localparam logic [1:0] RESET_MODE = 2'b00;
    localparam int RC = 2;
    localparam int SC = 8;
    localparam int DT = 255;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [1:0] mode_req_i = 2'b00;
    logic       mode_req_valid_i = 1'b0;
    logic       mode_req_ready_o;
    logic       chain_busy_i = 1'b0;
    logic [1:0] sel_o;
    logic       chain_resetn_o;
    logic       chain_en_o;
    logic       switching_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    logic [1:0] model_sel = RESET_MODE;
    logic       model_timeout = 1'b0;

    always #5 clk = ~clk;

    zigbee_mode_ctrl #(
        .RESET_MODE   (RESET_MODE),
        .RESET_CYCLES (RC),
        .SETTLE_CYCLES(SC),
        .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .mode_req_i      (mode_req_i),
        .mode_req_valid_i(mode_req_valid_i),
        .mode_req_ready_o(mode_req_ready_o),
        .chain_busy_i    (chain_busy_i),
        .sel_o           (sel_o),
        .chain_resetn_o  (chain_resetn_o),
        .chain_en_o      (chain_en_o),
        .switching_o     (switching_o),
        .timeout_o       (timeout_o)
    );

    // {sel, resetn, en, ready, switching, timeout}
    wire [6:0] obs = {sel_o, chain_resetn_o, chain_en_o,
                      mode_req_ready_o, switching_o, timeout_o};

    task automatic test_reset();
        logic [6:0] exp_v;
        reset_i = 1'b1;
        mode_req_valid_i = 1'b0;
        chain_busy_i = 1'b0;
        @(posedge clk);
        #2;
        exp_v = {RESET_MODE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, exp_v);
        end
        reset_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp_v = {RESET_MODE, (k >= RC), (k >= RC + SC),
                     (k >= RC + SC), (k < RC + SC), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_release k=%0d: got %b expected %b", k, obs, exp_v);
            end
        end
        model_sel = RESET_MODE;
        model_timeout = 1'b0;
    endtask

    // b = number of post-accept cycles the chain reports busy
    task automatic do_request(input logic [1:0] m, input int b, input string tag);
        logic [6:0] exp_v;
        logic [1:0] old;
        int n;
        int e;
        n = 0;
        while (mode_req_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (mode_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: got %b expected 1", tag, mode_req_ready_o);
        end
        old = model_sel;
        exp_v = {old, 1'b1, 1'b1, 1'b1, 1'b0, model_timeout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s pre_accept: got %b expected %b", tag, obs, exp_v);
        end
        mode_req_i = m;
        mode_req_valid_i = 1'b1;
        chain_busy_i = (b > 0);
        @(posedge clk);
        #1;
        mode_req_valid_i = 1'b0;
        mode_req_i = 2'($urandom);
        model_timeout = 1'b0;
        if (m == old) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                exp_v = {old, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL %s same_mode k=%0d: got %b expected %b", tag, k, obs, exp_v);
                end
            end
        end else begin
            e = (b >= DT) ? DT : b + 1;
            chain_busy_i = (1 <= b);
            for (int k = 0; k <= e + RC + SC + 1; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                    chain_busy_i = (k + 1 <= b);
                end
                exp_v = {(k >= e) ? m : old,
                         !((k >= e) && (k < e + RC)),
                         (k >= e + RC + SC),
                         (k >= e + RC + SC),
                         (k < e + RC + SC),
                         (k >= e) && (b >= DT)};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL %s switch m=%b b=%0d k=%0d: got %b expected %b",
                             tag, m, b, k, obs, exp_v);
                end
            end
            model_sel = m;
            model_timeout = (b >= DT);
        end
        chain_busy_i = 1'b0;
    endtask

    task automatic test_idle_switch();
        do_request(2'b10, 0, "idle_switch");
    endtask

    task automatic test_busy_drain();
        do_request(2'b11, 40, "busy_drain");
        do_request(2'b00, DT - 1, "busy_edge");
    endtask

    task automatic test_timeout();
        do_request(2'b01, 1000, "timeout");
    endtask

    task automatic test_same_mode();
        do_request(model_sel, 0, "same_mode");
    endtask

    task automatic test_random();
        logic [1:0] m;
        int b;
        int pick;
        for (int i = 0; i < 14; i++) begin
            m = 2'($urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            if (pick < 4) b = 0;
            else if (pick < 8) b = $urandom_range(1, 60);
            else if (pick == 8) b = DT - 1;
            else b = DT + $urandom_range(0, 20);
            do_request(m, b, "random");
        end
    endtask

    task automatic test_reset_mid_switch();
        logic [6:0] exp_v;
        logic [1:0] m;
        int n;
        m = ~model_sel;
        if (m == RESET_MODE) m = 2'b01;
        n = 0;
        while (mode_req_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        mode_req_i = m;
        mode_req_valid_i = 1'b1;
        chain_busy_i = 1'b0;
        @(posedge clk);
        #1;
        mode_req_valid_i = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        exp_v = {m, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_switch_settle: got %b expected %b", obs, exp_v);
        end
        reset_i = 1'b1;
        #1;
        exp_v = {RESET_MODE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_switch_async_reset: got %b expected %b", obs, exp_v);
        end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_idle_switch();
        test_busy_drain();
        test_timeout();
        test_same_mode();
        test_random();
        test_reset_mid_switch();
        do_request(2'b11, 3, "post_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
